// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, C-type functions,
// FSM states, ALU operations and every datapath mux select.
package mips_ctrl_pkg;

    localparam logic [3:0] OP_LOAD    = 4'b0000;
    localparam logic [3:0] OP_STORE   = 4'b0001;
    localparam logic [3:0] OP_JUMP    = 4'b0010;
    localparam logic [3:0] OP_BRANCHZ = 4'b0100;
    localparam logic [3:0] OP_CTYPE   = 4'b1000;
    localparam logic [3:0] OP_ADDI    = 4'b1100;
    localparam logic [3:0] OP_SUBI    = 4'b1101;
    localparam logic [3:0] OP_ANDI    = 4'b1110;
    localparam logic [3:0] OP_ORI     = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [2:0] WSEL_NOT   = 3'd0;
    localparam logic [2:0] WSEL_ALU   = 3'd1;
    localparam logic [2:0] WSEL_DATA2 = 3'd2;
    localparam logic [2:0] WSEL_R0    = 3'd3;
    localparam logic [2:0] WSEL_MDR   = 3'd4;

    localparam logic       MADR_INST = 1'b0;
    localparam logic       MADR_PC   = 1'b1;
    localparam logic       WADR_RI   = 1'b0;
    localparam logic       WADR_R0   = 1'b1;
    localparam logic       A_R0      = 1'b0;
    localparam logic       A_PC      = 1'b1;
    localparam logic [1:0] B_IMM     = 2'd0;
    localparam logic [1:0] B_ONE     = 2'd1;
    localparam logic [1:0] B_DATA2   = 2'd2;
    localparam logic [1:0] PC_ALUREG = 2'd0;
    localparam logic [1:0] PC_BZ     = 2'd1;
    localparam logic [1:0] PC_JMP    = 2'd2;
    localparam logic [1:0] PC_ALUOUT = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_LD_MEM  = 4'd2,
        S_LD_WB   = 4'd3,
        S_ST_MEM  = 4'd4,
        S_JMP     = 4'd5,
        S_BZ      = 4'd6,
        S_C_EXE   = 4'd7,
        S_I_EXE   = 4'd8,
        S_ALU_WB  = 4'd9,
        S_MV_TO   = 4'd10,
        S_MV_FROM = 4'd11,
        S_NOT_WB  = 4'd12,
        S_ILLEGAL = 4'd13
    } state_e;

    // Values equal the func bit index so the decoder can cast directly.
    typedef enum logic [2:0] {
        C_MOVETO   = 3'd0,
        C_MOVEFROM = 3'd1,
        C_ADD      = 3'd2,
        C_SUB      = 3'd3,
        C_AND      = 3'd4,
        C_OR       = 3'd5,
        C_NOT      = 3'd6,
        C_NOP      = 3'd7
    } c_kind_e;

    typedef enum logic [2:0] {
        AC_NONE  = 3'd0,
        AC_FETCH = 3'd1,
        AC_BZ    = 3'd2,
        AC_C     = 3'd3,
        AC_I     = 3'd4
    } alu_cls_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       reg_write_en;
        logic       mem_adr_sel;
        logic       reg_write_adr_sel;
        logic [2:0] reg_write_sel;
        logic       alu_src_a_sel;
        logic [1:0] alu_src_b_sel;
        logic [1:0] pc_sel;
        logic [1:0] alu_op;
    } ctrl_t;

    // Lowest set func bit wins; no bit set means NOP.
    function automatic c_kind_e c_decode(input logic [7:0] func);
        c_kind_e k;
        k = C_NOP;
        for (int i = 7; i >= 0; i--) begin
            if (func[i]) k = c_kind_e'(3'(i));
        end
        return k;
    endfunction

endpackage

// File: rtl/mips_alu_ctrl.sv
// ALU operation select: derived from the class of the current state plus the
// instruction's opcode low bits (immediate ops) or func field (C-type ops).
module mips_alu_ctrl
    import mips_ctrl_pkg::*;
(
    input  alu_cls_e   i_cls,
    input  logic [1:0] i_op_lo,
    input  logic [7:0] i_func,
    output logic [1:0] o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_cls)
            AC_FETCH: o_alu_op = ALU_ADD;
            AC_BZ:    o_alu_op = ALU_AND;
            AC_I:     o_alu_op = i_op_lo;
            AC_C: begin
                case (c_decode(i_func))
                    C_SUB:   o_alu_op = ALU_SUB;
                    C_AND:   o_alu_op = ALU_AND;
                    C_OR:    o_alu_op = ALU_OR;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            default: o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multi-cycle Moore control FSM for the 16-bit accumulator MIPS datapath.
// Every output is a function of the state (and the held IR), forced to 0 during reset.
module mips_controller
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        inst_bus,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               mem_write,
    output logic               mem_read,
    output logic               IR_write,
    output logic               reg_write_en,
    output logic               mem_adr_sel,
    output logic               reg_write_adr_sel,
    output logic [2:0]         reg_write_sel,
    output logic               ALU_src_A_sel,
    output logic [1:0]         ALU_src_B_sel,
    output logic [1:0]         pc_sel,
    output logic [1:0]         ALU_op_code,
    output logic [STATE_W-1:0] state_dbg
);

    state_e     r_state;
    state_e     w_next;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;
    alu_cls_e   w_alu_cls;
    logic [1:0] w_alu_op;
    logic [3:0] w_opcode;
    c_kind_e    w_ckind;
    logic       w_unused;

    assign w_opcode = inst_bus[15:12];
    assign w_ckind  = c_decode(inst_bus[7:0]);
    assign w_unused = ^inst_bus[11:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_LOAD:    w_next = S_LD_MEM;
                    OP_STORE:   w_next = S_ST_MEM;
                    OP_JUMP:    w_next = S_JMP;
                    OP_BRANCHZ: w_next = S_BZ;
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: w_next = S_I_EXE;
                    OP_CTYPE: begin
                        case (w_ckind)
                            C_MOVETO:   w_next = S_MV_TO;
                            C_MOVEFROM: w_next = S_MV_FROM;
                            C_ADD, C_SUB, C_AND, C_OR: w_next = S_C_EXE;
                            C_NOT:      w_next = S_NOT_WB;
                            default:    w_next = S_FETCH;
                        endcase
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_LD_MEM: w_next = S_LD_WB;
            S_C_EXE:  w_next = S_ALU_WB;
            S_I_EXE:  w_next = S_ALU_WB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_alu_cls = AC_NONE;
        case (r_state)
            S_FETCH: w_alu_cls = AC_FETCH;
            S_BZ:    w_alu_cls = AC_BZ;
            S_C_EXE: w_alu_cls = AC_C;
            S_I_EXE: w_alu_cls = AC_I;
            default: w_alu_cls = AC_NONE;
        endcase
    end

    mips_alu_ctrl u_alu_ctrl (
        .i_cls    (w_alu_cls),
        .i_op_lo  (w_opcode[1:0]),
        .i_func   (inst_bus[7:0]),
        .o_alu_op (w_alu_op)
    );

    always_comb begin
        w_ctrl        = '0;
        w_ctrl.alu_op = w_alu_op;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read      = 1'b1;
                w_ctrl.mem_adr_sel   = MADR_PC;
                w_ctrl.ir_write      = 1'b1;
                w_ctrl.alu_src_a_sel = A_PC;
                w_ctrl.alu_src_b_sel = B_ONE;
                w_ctrl.pc_sel        = PC_ALUOUT;
                w_ctrl.pc_write      = 1'b1;
            end
            S_LD_MEM: begin
                w_ctrl.mem_read    = 1'b1;
                w_ctrl.mem_adr_sel = MADR_INST;
            end
            S_LD_WB: begin
                w_ctrl.reg_write_en      = 1'b1;
                w_ctrl.reg_write_sel     = WSEL_MDR;
                w_ctrl.reg_write_adr_sel = WADR_R0;
            end
            S_ST_MEM: begin
                w_ctrl.mem_write   = 1'b1;
                w_ctrl.mem_adr_sel = MADR_INST;
            end
            S_JMP: begin
                w_ctrl.pc_sel   = PC_JMP;
                w_ctrl.pc_write = 1'b1;
            end
            S_BZ: begin
                w_ctrl.alu_src_a_sel = A_R0;
                w_ctrl.alu_src_b_sel = B_DATA2;
                w_ctrl.pc_sel        = PC_BZ;
                w_ctrl.pc_write_cond = 1'b1;
            end
            S_C_EXE: begin
                w_ctrl.alu_src_a_sel = A_R0;
                w_ctrl.alu_src_b_sel = B_DATA2;
            end
            S_I_EXE: begin
                w_ctrl.alu_src_a_sel = A_R0;
                w_ctrl.alu_src_b_sel = B_IMM;
            end
            S_ALU_WB: begin
                w_ctrl.reg_write_en      = 1'b1;
                w_ctrl.reg_write_sel     = WSEL_ALU;
                w_ctrl.reg_write_adr_sel = WADR_R0;
            end
            S_MV_TO: begin
                w_ctrl.reg_write_en      = 1'b1;
                w_ctrl.reg_write_sel     = WSEL_R0;
                w_ctrl.reg_write_adr_sel = WADR_RI;
            end
            S_MV_FROM: begin
                w_ctrl.reg_write_en      = 1'b1;
                w_ctrl.reg_write_sel     = WSEL_DATA2;
                w_ctrl.reg_write_adr_sel = WADR_R0;
            end
            S_NOT_WB: begin
                w_ctrl.reg_write_en      = 1'b1;
                w_ctrl.reg_write_sel     = WSEL_NOT;
                w_ctrl.reg_write_adr_sel = WADR_R0;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign w_out = rst ? w_ctrl : '0;

    assign pc_write          = w_out.pc_write;
    assign pc_write_cond     = w_out.pc_write_cond;
    assign mem_write         = w_out.mem_write;
    assign mem_read          = w_out.mem_read;
    assign IR_write          = w_out.ir_write;
    assign reg_write_en      = w_out.reg_write_en;
    assign mem_adr_sel       = w_out.mem_adr_sel;
    assign reg_write_adr_sel = w_out.reg_write_adr_sel;
    assign reg_write_sel     = w_out.reg_write_sel;
    assign ALU_src_A_sel     = w_out.alu_src_a_sel;
    assign ALU_src_B_sel     = w_out.alu_src_b_sel;
    assign pc_sel            = w_out.pc_sel;
    assign ALU_op_code       = w_out.alu_op;
    assign state_dbg         = rst ? STATE_W'(r_state) : '0;

endmodule
